// File: rtl/gray_counter_if.sv
// gray_counter_if: groups the control and result signals of gray_counter.
//   master : drives en, up, load, load_gray, load_val; observes binary, gray, tc
//   slave  : the counter side (observes controls, drives binary, gray, tc)
interface gray_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic             load_gray;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] binary;
    logic [WIDTH-1:0] gray;
    logic             tc;

    modport master (
        output en, up, load, load_gray, load_val,
        input  binary, gray, tc
    );

    modport slave (
        input  en, up, load, load_gray, load_val,
        output binary, gray, tc
    );
endinterface

// File: rtl/gray_counter.sv
// gray_counter: up/down counter with registered binary and Gray outputs.
// Loadable from a binary or Gray-encoded value; wraps or saturates at limits.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (binary=RESET_VAL, tc=0)
//   bus : gray_counter_if slave
//         en/up       step enable and direction (1 = increment)
//         load        load load_val (overrides en)
//         load_gray   load_val is Gray-encoded when 1
//         binary/gray current count, gray == binary ^ (binary >> 1)
//         tc          one-cycle flag for a step attempted at a limit
module gray_counter #(
    parameter int WIDTH     = 4,
    parameter bit SATURATE  = 1'b0,
    parameter int RESET_VAL = 0
) (
    input  logic          clk,
    input  logic          rst,
    gray_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
    localparam logic [WIDTH-1:0] MAX_VAL  = '1;

    logic [WIDTH-1:0] binary_q, binary_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] load_bin;

    always_comb begin
        // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
        load_bin = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            load_bin[i] = ^(bus.load_val >> i);
        end

        binary_d = binary_q;
        tc_d     = 1'b0;
        if (bus.load) begin
            binary_d = bus.load_gray ? load_bin : bus.load_val;
        end else if (bus.en) begin
            if (bus.up) begin
                if (binary_q == MAX_VAL) begin
                    tc_d = 1'b1;
                    if (!SATURATE) binary_d = '0;
                end else begin
                    binary_d = binary_q + WIDTH'(1);
                end
            end else begin
                if (binary_q == '0) begin
                    tc_d = 1'b1;
                    if (!SATURATE) binary_d = MAX_VAL;
                end else begin
                    binary_d = binary_q - WIDTH'(1);
                end
            end
        end
        gray_d = binary_d ^ (binary_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            binary_q <= RST_BIN;
            gray_q   <= RST_GRAY;
            tc_q     <= 1'b0;
        end else begin
            binary_q <= binary_d;
            gray_q   <= gray_d;
            tc_q     <= tc_d;
        end
    end

    assign bus.binary = binary_q;
    assign bus.gray   = gray_q;
    assign bus.tc     = tc_q;
endmodule

// File: tb/tb_gray_counter.sv
// Bench: four counter configurations share one stimulus stream.
//   d0: WIDTH=4 wrap, d1: WIDTH=4 saturate, d2: WIDTH=4 RESET_VAL=5, d3: WIDTH=8 wrap
module tb_gray_counter;
    typedef struct {
        int unsigned bin;
        int unsigned gry;
        bit          tc;
        bit          step;
    } exp_t;

    logic       clk = 1'b1;
    logic       s_rst = 1'b1;
    logic       s_en = 1'b0;
    logic       s_up = 1'b0;
    logic       s_load = 1'b0;
    logic       s_load_gray = 1'b0;
    logic [7:0] s_load_val = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic void check(string name, int unsigned act, int unsigned req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g
        localparam int W   = (i == 3) ? 8 : 4;
        localparam bit SAT = (i == 1);
        localparam int RV  = (i == 2) ? 5 : 0;
        localparam int unsigned MAXV = (1 << W) - 1;

        gray_counter_if #(.WIDTH(W)) bus ();

        assign bus.en        = s_en;
        assign bus.up        = s_up;
        assign bus.load      = s_load;
        assign bus.load_gray = s_load_gray;
        assign bus.load_val  = s_load_val[W-1:0];

        gray_counter #(.WIDTH(W), .SATURATE(SAT), .RESET_VAL(RV)) dut (
            .clk (clk),
            .rst (s_rst),
            .bus (bus)
        );

        exp_t q[$];

        // Find the binary value whose Gray code matches g by exhaustive search.
        function automatic int unsigned gray_to_bin(int unsigned g);
            for (int unsigned b = 0; b <= MAXV; b++)
                if ((b ^ (b >> 1)) == g) return b;
            return 0;
        endfunction

        // Reference model: reacts to the inputs the driver set on this negedge.
        initial begin : model
            int unsigned cnt;
            int unsigned prev;
            int unsigned lv;
            exp_t e;
            cnt = 0;
            forever begin
                @(negedge clk);
                #1;
                prev   = cnt;
                e.tc   = 1'b0;
                e.step = 1'b0;
                lv     = int'(s_load_val) & MAXV;
                if (s_rst) begin
                    cnt = RV;
                end else if (s_load) begin
                    cnt = s_load_gray ? gray_to_bin(lv) : lv;
                end else if (s_en) begin
                    if (s_up) begin
                        if (cnt == MAXV) begin
                            e.tc = 1'b1;
                            if (!SAT) cnt = 0;
                        end else cnt = cnt + 1;
                    end else begin
                        if (cnt == 0) begin
                            e.tc = 1'b1;
                            if (!SAT) cnt = MAXV;
                        end else cnt = cnt - 1;
                    end
                    e.step = (cnt != prev);
                end
                e.bin = cnt;
                e.gry = cnt ^ (cnt >> 1);
                q.push_back(e);
            end
        end

        // Monitor: outputs are valid every cycle once the model has produced an entry.
        initial begin : monitor
            exp_t        e;
            int unsigned b, gy, pg;
            bit          armed;
            armed = 1'b0;
            pg    = 0;
            forever begin
                @(posedge clk);
                #1;
                if (q.size() == 0) begin
                    if (armed) check($sformatf("d%0d.queue_underflow", i), 1, 0);
                end else begin
                    armed = 1'b1;
                    e  = q.pop_front();
                    b  = int'(bus.binary);
                    gy = int'(bus.gray);
                    check($sformatf("d%0d.binary", i), b, e.bin);
                    check($sformatf("d%0d.gray", i), gy, e.gry);
                    check($sformatf("d%0d.tc", i), int'(bus.tc), int'(e.tc));
                    check($sformatf("d%0d.gray_encoding", i), gy, b ^ (b >> 1));
                    if (e.step)
                        check($sformatf("d%0d.gray_hamming", i), $countones(gy ^ pg), 1);
                    pg = gy;
                end
            end
        end
    end

    task automatic drive(input bit rst, input bit en, input bit up,
                         input bit ld, input bit lg, input logic [7:0] val);
        @(negedge clk);
        s_rst       = rst;
        s_en        = en;
        s_up        = up;
        s_load      = ld;
        s_load_gray = lg;
        s_load_val  = val;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        // Reset.
        drive(1, 0, 0, 0, 0, 8'h00);
        drive(1, 0, 0, 0, 0, 8'h00);
        // Count up 16 steps: full 4-bit Gray sequence and one wrap.
        for (int k = 0; k < 16; k++) drive(0, 1, 1, 0, 0, 8'h00);
        drive(0, 0, 1, 0, 0, 8'h00);
        // Down from zero wraps to MAX, then steps to MAX-1.
        drive(1, 0, 0, 0, 0, 8'h00);
        drive(0, 1, 0, 0, 0, 8'h00);
        drive(0, 1, 0, 0, 0, 8'h00);
        // Gray load of 1011, alone and together with en.
        drive(0, 0, 0, 1, 1, 8'h0B);
        drive(0, 1, 1, 1, 1, 8'h0B);
        drive(0, 0, 1, 0, 0, 8'h00);
        // Load MAX, then push against the upper limit, idle, and step down.
        drive(0, 0, 0, 1, 0, 8'hFF);
        for (int k = 0; k < 3; k++) drive(0, 1, 1, 0, 0, 8'h00);
        drive(0, 0, 1, 0, 0, 8'h00);
        drive(0, 1, 0, 0, 0, 8'h00);
        // Reset while load and en are both requested mid-count.
        for (int k = 0; k < 3; k++) drive(0, 1, 1, 0, 0, 8'h00);
        drive(1, 1, 1, 1, 0, 8'h0A);
        drive(0, 0, 0, 0, 0, 8'h00);
        // Full up then down sweeps (covers 8-bit wrap in both directions).
        drive(1, 0, 0, 0, 0, 8'h00);
        for (int k = 0; k < 260; k++) drive(0, 1, 1, 0, 0, 8'h00);
        for (int k = 0; k < 260; k++) drive(0, 1, 0, 0, 0, 8'h00);
        // Randomized traffic with occasional reset and loads.
        for (int k = 0; k < 2000; k++) begin
            drive($urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 80,
                  1'($urandom),
                  $urandom_range(0, 99) < 10,
                  1'($urandom),
                  8'($urandom));
        end
        drive(0, 0, 0, 0, 0, 8'h00);
        drive(0, 0, 0, 0, 0, 8'h00);
        @(posedge clk);
        #3;
        check("d0.queue_drained", g[0].q.size(), 0);
        check("d1.queue_drained", g[1].q.size(), 0);
        check("d2.queue_drained", g[2].q.size(), 0);
        check("d3.queue_drained", g[3].q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
